// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: launches the shared Mult/Div units, waits for completion and commits HI/LO or aborts.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MEM_WAIT       = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic       timeout,
  output logic       mult_start,
  input  logic       mult_end,
  output logic       div_start,
  input  logic       div_end,
  input  logic       div_0_exception,
  output logic       div_src,
  output logic       div_or_mult,
  output logic       high_write,
  output logic       low_write
);
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, WRITE, DONE, EXC} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       zero_q, zero_d;
  logic       is_div, sel_end, active;
  always_comb begin
    is_div  = op_q != 2'b00;
    sel_end = is_div ? div_end : mult_end;
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: if (req && op != 2'b11) begin
        op_d    = op;
        cnt_d   = 8'd0;
        state_d = (op == 2'b10 && MEM_WAIT > 0) ? FETCH : START;
      end
      FETCH: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == 8'(MEM_WAIT - 1)) ? START : FETCH;
      end
      START: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      // exception beats completion, completion beats the watchdog
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (is_div && div_0_exception) begin
          state_d = EXC;
          zero_d  = 1'b1;
        end else if (sel_end) begin
          state_d = WRITE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = EXC;
          zero_d  = 1'b0;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 2'b00;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
    end
  end
  assign active      = state_q inside {FETCH, START, WAIT, WRITE};
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign div_zero    = state_q == EXC && zero_q;
  assign timeout     = state_q == EXC && !zero_q;
  assign mult_start  = state_q == START && !is_div;
  assign div_start   = state_q == START && is_div;
  assign div_src     = active && op_q == 2'b10;
  assign div_or_mult = active && op_q == 2'b00;
  assign high_write  = state_q == WRITE;
  assign low_write   = state_q == WRITE;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized transactions checked cycle by cycle against a phase-timeline model.
module tb_muldiv_sequencer;
  localparam int TO = 8;
  localparam int MW = 1;
  logic clock = 1'b0, reset = 1'b0, req = 1'b0;
  logic [1:0] op = 2'b00;
  logic mult_end = 1'b0, div_end = 1'b0, div_0_exception = 1'b0;
  logic busy, done, div_zero, timeout, mult_start, div_start, div_src, div_or_mult, high_write, low_write;
  int total = 0, bad = 0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .MEM_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .busy(busy), .done(done),
    .div_zero(div_zero), .timeout(timeout), .mult_start(mult_start), .mult_end(mult_end),
    .div_start(div_start), .div_end(div_end), .div_0_exception(div_0_exception),
    .div_src(div_src), .div_or_mult(div_or_mult), .high_write(high_write), .low_write(low_write)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] dut_vec();
    return {busy, done, div_zero, timeout, mult_start, div_start, div_src, div_or_mult, high_write, low_write};
  endfunction

  // phases: 0 idle, 1 fetch, 2 start, 3 wait, 4 write, 5 done, 6 abort; res: 0 commit, 1 zero, 2 timeout
  function automatic logic [9:0] exp_vec(input int ph, input logic [1:0] o, input int res);
    logic act;
    act = ph >= 1 && ph <= 4;
    return {ph != 0, ph == 5, ph == 6 && res == 1, ph == 6 && res == 2, ph == 2 && o == 2'b00,
            ph == 2 && o != 2'b00, act && o == 2'b10, act && o == 2'b00, ph == 4, ph == 4};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input bit poke11, input string name);
    for (int i = 0; i < n; i++) begin
      req = poke11;
      op = poke11 ? 2'b11 : 2'($urandom);
      mult_end = 1'($urandom);
      div_end = 1'($urandom);
      div_0_exception = 1'($urandom);
      step();
      total++;
      if (dut_vec() !== 10'd0) begin
        bad++;
        $display("FAIL %s idle %0d: got %b want %b", name, i, dut_vec(), 10'd0);
      end
    end
    req = 1'b0;
  endtask

  // entered and left in an already-checked IDLE cycle, so calls chain back-to-back
  task automatic run_op(input logic [1:0] o, input int end_k, input int exc_k, input bit noise, input string name);
    int f, w, res, len, ph, k;
    bit is_div;
    logic sel;
    is_div = o != 2'b00;
    f = (o == 2'b10) ? MW : 0;
    res = 2;
    w = TO;
    for (int i = 1; i <= TO; i++) begin
      if (is_div && exc_k == i) begin res = 1; w = i; break; end
      if (end_k == i) begin res = 0; w = i; break; end
    end
    len = f + 1 + w + (res == 0 ? 2 : 1);
    req = 1'b1;
    op = o;
    mult_end = noise ? 1'($urandom) : 1'b0;
    div_end = noise ? 1'($urandom) : 1'b0;
    div_0_exception = noise ? 1'($urandom) : 1'b0;
    step();
    for (int c = 1; c <= len + 1; c++) begin
      k = c - f - 1;
      if (c <= f) ph = 1;
      else if (c == f + 1) ph = 2;
      else if (k <= w) ph = 3;
      else if (res == 0 && c == f + w + 2) ph = 4;
      else if (res == 0 && c == f + w + 3) ph = 5;
      else if (res != 0 && c == f + w + 2) ph = 6;
      else ph = 0;
      total++;
      if (dut_vec() !== exp_vec(ph, o, res)) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b want %b", name, c, dut_vec(), exp_vec(ph, o, res));
      end
      if (c == len + 1) break;
      req = noise ? 1'($urandom) : 1'b0;
      op = 2'($urandom);
      sel = (ph == 3) ? (k == end_k) : (noise ? 1'($urandom) : 1'b0);
      mult_end = is_div ? (noise ? 1'($urandom) : 1'b0) : sel;
      div_end = is_div ? sel : (noise ? 1'($urandom) : 1'b0);
      div_0_exception = (is_div && ph == 3) ? (k == exc_k) : (noise ? 1'($urandom) : 1'b0);
      step();
    end
    req = 1'b0;
    mult_end = 1'b0;
    div_end = 1'b0;
    div_0_exception = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (dut_vec() !== 10'd0) begin
      bad++;
      $display("FAIL reset_hold: got %b want %b", dut_vec(), 10'd0);
    end
    reset = 1'b1;
    idle(10, 1'b0, "reset_idle");
  endtask

  task automatic test_mult();
    run_op(2'b00, 3, 0, 1'b0, "mult_n3");
    idle(1, 1'b0, "mult_after");
  endtask

  task automatic test_divm();
    run_op(2'b10, 5, 0, 1'b0, "divm_n5");
    idle(1, 1'b0, "divm_after");
  endtask

  task automatic test_div_zero();
    run_op(2'b01, 2, 2, 1'b0, "div_zero_vs_end");
    run_op(2'b10, 0, 3, 1'b0, "divm_zero");
    idle(1, 1'b0, "div_zero_after");
  endtask

  task automatic test_timeout();
    run_op(2'b00, 0, 0, 1'b0, "mult_timeout");
    run_op(2'b01, 3, 0, 1'b0, "b2b_after_timeout");
    run_op(2'b00, TO, 0, 1'b0, "end_beats_timeout");
    run_op(2'b00, 2, 1, 1'b0, "mult_ignores_exc");
  endtask

  task automatic test_ignored();
    idle(4, 1'b1, "op11");
    run_op(2'b01, 4, 0, 1'b1, "div_noisy");
    idle(1, 1'b0, "ignored_after");
  endtask

  task automatic test_reset_mid();
    req = 1'b1;
    op = 2'b00;
    step();
    req = 1'b0;
    total++;
    if (dut_vec() !== exp_vec(2, 2'b00, 0)) begin
      bad++;
      $display("FAIL mid_start: got %b want %b", dut_vec(), exp_vec(2, 2'b00, 0));
    end
    req = 1'b1;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 10'd0) begin
      bad++;
      $display("FAIL mid_async_clear: got %b want %b", dut_vec(), 10'd0);
    end
    mult_end = 1'b1;
    step();
    step();
    reset = 1'b1;
    mult_end = 1'b0;
    req = 1'b0;
    idle(10, 1'b0, "mid_after_release");
  endtask

  task automatic test_random();
    logic [1:0] o;
    int e, x;
    for (int t = 0; t < 30; t++) begin
      o = 2'($urandom_range(0, 2));
      e = $urandom_range(0, 9);
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
      run_op(o, e, x, 1'b1, "random");
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), 1'($urandom), "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divm();
    test_div_zero();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
